// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver: start, DATA_W data bits LSB first, parity, stop.
// Optional 3-sample majority vote per bit when RX_MAJORITY_VOTE_EN is defined.
module uart_rx_sipo #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              baud_clk,
  input  logic              reset,
  input  logic              data_rx,
  input  logic              parity_odd,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [TW-1:0] TICK_S0  = TW'(MID - 2);
  localparam logic [TW-1:0] TICK_S1  = TW'(MID - 1);
  localparam logic [TW-1:0] TICK_DEC = TW'(MID);
`else
  localparam logic [TW-1:0] TICK_DEC = TW'(MID - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic              rx_meta_q, rx_meta_d;
  logic              rx_s_q, rx_s_d;
  logic              rx_prev_q, rx_prev_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;

  logic start_edge;
  logic dec_tick;
  logic bit_val;

  // Edge qualifier needs the line seen high, so a held break never restarts.
  assign start_edge = rx_prev_q & ~rx_s_q;
  assign dec_tick   = (tick_q == TICK_DEC);

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] smp_q, smp_d;

  always_comb begin
    smp_d = smp_q;
    if (tick_q == TICK_S0) smp_d[0] = rx_s_q;
    if (tick_q == TICK_S1) smp_d[1] = rx_s_q;
  end

  always_ff @(posedge baud_clk) begin
    if (reset) smp_q <= 2'b11;
    else       smp_q <= smp_d;
  end

  assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
`else
  assign bit_val = rx_s_q;
`endif

  // FSM state register
  always_ff @(posedge baud_clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_edge) state_d = S_START;
      S_START:  if (dec_tick) state_d = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (dec_tick && (bit_idx_q == BIT_LAST)) state_d = S_PARITY;
      S_PARITY: if (dec_tick) state_d = S_STOP;
      S_STOP:   if (dec_tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rx_busy = (state_q != S_IDLE);
  end

  always_comb begin
    rx_meta_d = data_rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;

    // Counter sits at 0 in IDLE so the first START cycle is tick 0.
    if (state_q == S_IDLE)       tick_d = '0;
    else if (tick_q == TICK_LAST) tick_d = '0;
    else                         tick_d = tick_q + TW'(1);

    bit_idx_d = bit_idx_q;
    if (state_q == S_IDLE) bit_idx_d = '0;
    else if ((state_q == S_DATA) && dec_tick && (bit_idx_q != BIT_LAST))
      bit_idx_d = bit_idx_q + BW'(1);

    shreg_d = shreg_q;
    if ((state_q == S_DATA) && dec_tick)
      shreg_d = {bit_val, shreg_q[DATA_W-1:1]};

    perr_d = perr_q;
    if ((state_q == S_PARITY) && dec_tick)
      perr_d = (^shreg_q) ^ bit_val ^ parity_odd;

    data_valid_d = (state_q == S_STOP) && dec_tick;
    data_out_d   = data_valid_d ? shreg_q  : data_out_q;
    parity_err_d = data_valid_d ? perr_q   : parity_err_q;
    frame_err_d  = data_valid_d ? ~bit_val : frame_err_q;
  end

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      tick_q       <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      tick_q       <= tick_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Scoreboard bench for uart_rx_sipo: frames are serialised on the line, expected
// records queued at drive time and matched against data_valid captures.
module tb_uart_rx_sipo;

  localparam int DATA_W = 8;
  localparam int OS     = 16;
  localparam int FRAME  = 11 * OS;

  logic              baud_clk = 1'b0;
  logic              reset;
  logic              data_rx;
  logic              parity_odd;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              rx_busy;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   vld_cycles = 0;
  int   vld_pulses = 0;
  int   busy_cycles = 0;
  logic vld_prev = 1'b0;

  uart_rx_sipo #(.DATA_W(DATA_W), .OVERSAMPLE(OS)) dut (
    .baud_clk  (baud_clk),
    .reset     (reset),
    .data_rx   (data_rx),
    .parity_odd(parity_odd),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 baud_clk = ~baud_clk;

  // Monitor samples on the falling edge, half a cycle clear of the DUT.
  always @(negedge baud_clk) begin
    vld_prev <= (data_valid === 1'b1);
    if (data_valid === 1'b1) begin
      obs_q.push_back(rec_t'{data_out, parity_err, frame_err});
      vld_cycles <= vld_cycles + 1;
      if (!vld_prev) vld_pulses <= vld_pulses + 1;
    end
    if (rx_busy === 1'b1) busy_cycles <= busy_cycles + 1;
  end

  task automatic exp_push(input logic [DATA_W-1:0] d, input logic pe, input logic fe);
    exp_q.push_back(rec_t'{d, pe, fe});
  endtask

  // Line offset i of a frame: bit n = i/OS (0 start, 1..8 data, 9 parity, 10 stop).
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic stop,
                            input int glitch, input int len);
    for (int i = 0; i < len; i++) begin
      int   n;
      logic v;
      n = i / OS;
      if (n == 0)      v = 1'b0;
      else if (n <= 8) v = d[n-1];
      else if (n == 9) v = p;
      else             v = stop;
      if (i == glitch) v = ~v;
      @(negedge baud_clk);
      data_rx = v;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge baud_clk);
      data_rx = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    data_rx = 1'b1;
    parity_odd = 1'b0;
    repeat (4) @(negedge baud_clk);
    n_chk++;
    if ({data_out, data_valid, parity_err, frame_err, rx_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0",
               data_out, data_valid, parity_err, frame_err, rx_busy);
    end
    reset = 1'b0;
    idle(20);
  endtask

  task automatic test_basic;
    rec_t e, o;
    exp_push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, -1, FRAME);
    idle(32);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_count: got %0d frames, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic_frame: got %h/%b/%b, want %h/%b/%b", o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
      end
    end
    n_chk++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: got %b, want 0", rx_busy);
    end
    n_chk++;
    if (vld_cycles != vld_pulses) begin
      n_fail++;
      $display("FAIL valid_width: got %0d cycles for %0d pulses, want equal", vld_cycles, vld_pulses);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_false_start;
    int b0, v0;
    b0 = busy_cycles;
    v0 = vld_pulses;
    for (int i = 0; i < 4; i++) begin
      @(negedge baud_clk);
      data_rx = 1'b0;
    end
    idle(40);
    n_chk++;
    if (busy_cycles - b0 < 1) begin
      n_fail++;
      $display("FAIL false_start_busy: got %0d busy cycles, want >0", busy_cycles - b0);
    end
    n_chk++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL false_start_idle: got busy=%b, want 0", rx_busy);
    end
    n_chk++;
    if (vld_pulses != v0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL false_start_valid: got %0d pulses, want 0", vld_pulses - v0);
    end
    obs_q.delete();
  endtask

  task automatic test_parity;
    rec_t e, o;
    parity_odd = 1'b0;
    exp_push(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, -1, FRAME);
    idle(16);
    parity_odd = 1'b1;
    exp_push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, -1, FRAME);
    idle(32);
    parity_odd = 1'b0;
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL parity_count: got %0d frames, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL parity_frame: got %h/%b/%b, want %h/%b/%b", o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_frame_err;
    rec_t e, o;
    exp_push(8'h81, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, -1, FRAME);
    // Extend the low stop into a break before the line recovers.
    for (int i = 0; i < 48; i++) begin
      @(negedge baud_clk);
      data_rx = 1'b0;
    end
    idle(32);
    n_chk++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_err_hold: got %b, want 1", frame_err);
    end
    exp_push(8'h42, 1'b0, 1'b0);
    send_frame(8'h42, 1'b0, 1'b1, -1, FRAME);
    idle(32);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL frame_err_count: got %0d frames, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL frame_err_frame: got %h/%b/%b, want %h/%b/%b", o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    rec_t e, o;
    exp_push(8'h00, 1'b0, 1'b0);
    exp_push(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, -1, FRAME);
    send_frame(8'hFF, 1'b0, 1'b1, -1, FRAME);
    idle(32);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d frames, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b_frame: got %h/%b/%b, want %h/%b/%b", o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    rec_t e, o;
    int   v0;
    // Abort mid data bit 4 (line offset 88 of frame).
    send_frame(8'h96, 1'b0, 1'b1, -1, 88);
    @(negedge baud_clk);
    reset = 1'b1;
    data_rx = 1'b1;
    repeat (3) @(negedge baud_clk);
    n_chk++;
    if ({data_out, data_valid, parity_err, frame_err, rx_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_state: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0",
               data_out, data_valid, parity_err, frame_err, rx_busy);
    end
    reset = 1'b0;
    v0 = vld_pulses;
    idle(40);
    n_chk++;
    if (vld_pulses != v0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_valid: got %0d pulses, want 0", vld_pulses - v0);
    end
    obs_q.delete();
    exp_push(8'h69, 1'b0, 1'b0);
    send_frame(8'h69, 1'b0, 1'b1, -1, FRAME);
    idle(32);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_mid_count: got %0d frames, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_frame: got %h/%b/%b, want %h/%b/%b", o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch;
    rec_t e, o;
    // Offset 56 is the line cycle the receiver samples at tick MID-1 of data bit 2.
`ifdef RX_MAJORITY_VOTE_EN
    exp_push(8'h55, 1'b0, 1'b0);
`else
    exp_push(8'h51, 1'b1, 1'b0);
`endif
    send_frame(8'h55, 1'b0, 1'b1, 56, FRAME);
    idle(32);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL glitch_count: got %0d frames, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL glitch_frame: got %h/%b/%b, want %h/%b/%b", o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset;
    test_basic;
    test_false_start;
    test_parity;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_glitch;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
